// File: rtl/mesh_net_iface.sv
// Mesh network interface: packs CPU words into addressed flits for the router
// and filters router flits addressed to this node back to the CPU.

module mesh_net_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [AW:0]      count_next_s;
  logic             full_r;
  logic             empty_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s = push && !full_r;
  assign do_pop_s  = pop && !empty_r;

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_next_s = count_r + (AW+1)'(1);
      2'b01:   count_next_s = count_r - (AW+1)'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Storage, pointers and registered full/empty flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == (AW+1)'(DEPTH));
      empty_r <= (count_next_s == (AW+1)'(0));
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign full  = full_r;
  assign empty = empty_r;
endmodule

module mesh_net_iface #(
  parameter int MY_X   = 1,
  parameter int MY_Y   = 1,
  parameter int MESH_X = 3,
  parameter int MESH_Y = 3,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_tx_valid,
  output logic        cpu_tx_ready,
  input  logic [15:0] cpu_tx_dst_x,
  input  logic [15:0] cpu_tx_dst_y,
  input  logic [31:0] cpu_tx_data,
  output logic        rt_in_valid,
  input  logic        rt_in_ready,
  output logic [63:0] rt_in_flit,
  input  logic        rt_out_valid,
  output logic        rt_out_ready,
  input  logic [63:0] rt_out_flit,
  output logic        cpu_rx_valid,
  input  logic        cpu_rx_ready,
  output logic [31:0] cpu_rx_data,
  output logic [15:0] tx_count,
  output logic [15:0] rx_count,
  output logic [15:0] drop_count,
  output logic [15:0] err_count,
  output logic        tx_full,
  output logic        rx_full
);
  localparam logic [15:0] MY_X_C   = 16'(MY_X);
  localparam logic [15:0] MY_Y_C   = 16'(MY_Y);
  localparam logic [15:0] MESH_X_C = 16'(MESH_X);
  localparam logic [15:0] MESH_Y_C = 16'(MESH_Y);

  logic        tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic        tx_accept_s, tx_legal_s, tx_push_s, tx_err_s;
  logic        rx_accept_s, rx_match_s, rx_push_s, rx_drop_s;
  logic [15:0] tx_count_r, rx_count_r, drop_count_r, err_count_r;

  function automatic logic [15:0] sat_inc(input logic [15:0] value, input logic en);
    if (en && (value != 16'hFFFF)) begin
      return value + 16'd1;
    end else begin
      return value;
    end
  endfunction

  assign tx_legal_s  = (cpu_tx_dst_x >= 16'd1) && (cpu_tx_dst_x <= MESH_X_C) &&
                       (cpu_tx_dst_y >= 16'd1) && (cpu_tx_dst_y <= MESH_Y_C);
  assign tx_accept_s = cpu_tx_valid && !tx_full_s;
  assign tx_push_s   = tx_accept_s && tx_legal_s;
  assign tx_err_s    = tx_accept_s && !tx_legal_s;

  assign rx_match_s  = (rt_out_flit[63:48] == MY_X_C) && (rt_out_flit[47:32] == MY_Y_C);
  assign rx_accept_s = rt_out_valid && !rx_full_s;
  assign rx_push_s   = rx_accept_s && rx_match_s;
  assign rx_drop_s   = rx_accept_s && !rx_match_s;

  mesh_net_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push_s),
    .push_data ({cpu_tx_dst_x, cpu_tx_dst_y, cpu_tx_data}),
    .pop       (rt_in_ready),
    .head      (rt_in_flit),
    .full      (tx_full_s),
    .empty     (tx_empty_s)
  );

  mesh_net_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push_s),
    .push_data (rt_out_flit[31:0]),
    .pop       (cpu_rx_ready),
    .head      (cpu_rx_data),
    .full      (rx_full_s),
    .empty     (rx_empty_s)
  );

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_count_r   <= 16'd0;
      rx_count_r   <= 16'd0;
      drop_count_r <= 16'd0;
      err_count_r  <= 16'd0;
    end else begin
      tx_count_r   <= sat_inc(tx_count_r, tx_push_s);
      rx_count_r   <= sat_inc(rx_count_r, rx_push_s);
      drop_count_r <= sat_inc(drop_count_r, rx_drop_s);
      err_count_r  <= sat_inc(err_count_r, tx_err_s);
    end
  end

  assign cpu_tx_ready = !tx_full_s;
  assign rt_in_valid  = !tx_empty_s;
  assign rt_out_ready = !rx_full_s;
  assign cpu_rx_valid = !rx_empty_s;
  assign tx_full      = tx_full_s;
  assign rx_full      = rx_full_s;
  assign tx_count     = tx_count_r;
  assign rx_count     = rx_count_r;
  assign drop_count   = drop_count_r;
  assign err_count    = err_count_r;
endmodule
